// File: rtl/memory_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : memory_cycle
//  Description : RISC-V pipeline MEM stage. It takes the EX/MEM register
//                outputs and does word loads and stores on a local data
//                memory. It drives the MEM/WB pipeline register, which feeds
//                writeback. Misaligned or out-of-range accesses set a sticky
//                error flag and capture the faulting byte address.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH        data memory size in 32-bit words (power of two, >= 4)
//    IDX_W        word-index width, log2(DEPTH)
//  Ports
//    clk          rising-edge clock
//    rst          asynchronous active-high reset
//    RegWriteM    instruction in MEM writes the register file
//    MemWriteM    store request
//    ResultSrcM   1 = load (writeback uses ReadDataW), 0 = ALU result
//    RD_M         destination register
//    PCPlus4M     PC+4 of the instruction in MEM
//    WriteDataM   store data
//    ALU_ResultM  byte address for load/store, or ALU result
//    ErrClr       clears MemErr / MemErrAddr
//    RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW
//                 MEM/WB pipeline register outputs
//    MemErr       sticky access-error flag
//    MemErrAddr   address of the first faulting access since the last clear
// ============================================================================
module memory_cycle #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    input  logic        ErrClr,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic        MemErr,
    output logic [31:0] MemErrAddr
);

    // Byte size of the memory. Any address at or above this value is out of range.
    localparam logic [31:0] c_MEM_BYTES = 32'(DEPTH * 4);

    logic [31:0] mem [DEPTH];

    logic             w_access;
    logic             w_bad;
    logic             w_store_ok;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_read_data_m;

    logic        reg_write_q,   reg_write_d;
    logic        result_src_q,  result_src_d;
    logic [4:0]  rd_q,          rd_d;
    logic [31:0] pc_plus4_q,    pc_plus4_d;
    logic [31:0] alu_result_q,  alu_result_d;
    logic [31:0] read_data_q,   read_data_d;
    logic        mem_err_q,     mem_err_d;
    logic [31:0] mem_err_addr_q, mem_err_addr_d;

    always_comb begin
        w_access   = MemWriteM | ResultSrcM;
        w_bad      = w_access & ((ALU_ResultM[1:0] != 2'b00) | (ALU_ResultM >= c_MEM_BYTES));
        w_store_ok = MemWriteM & ~w_bad;
        w_idx      = ALU_ResultM[IDX_W+1:2];
        // Load data is returned only for a clean, pure load. A store that also
        // asserts ResultSrcM is treated as a store and reads back zero.
        if (ResultSrcM && !MemWriteM && !w_bad) begin
            w_read_data_m = mem[w_idx];
        end else begin
            w_read_data_m = 32'd0;
        end
    end

    // Memory array is not reset. A store in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_store_ok) begin
            mem[w_idx] <= WriteDataM;
        end
    end

    always_comb begin
        reg_write_d    = RegWriteM & ~w_bad;
        result_src_d   = ResultSrcM;
        rd_d           = RD_M;
        pc_plus4_d     = PCPlus4M;
        alu_result_d   = ALU_ResultM;
        read_data_d    = w_read_data_m;
        mem_err_d      = mem_err_q;
        mem_err_addr_d = mem_err_addr_q;
        // Capture beats clear. With ErrClr asserted the flag is treated as
        // already cleared, so a bad access in the same cycle records its address.
        if (w_bad && (!mem_err_q || ErrClr)) begin
            mem_err_d      = 1'b1;
            mem_err_addr_d = ALU_ResultM;
        end else if (ErrClr) begin
            mem_err_d      = 1'b0;
            mem_err_addr_d = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q    <= 1'b0;
            result_src_q   <= 1'b0;
            rd_q           <= 5'd0;
            pc_plus4_q     <= 32'd0;
            alu_result_q   <= 32'd0;
            read_data_q    <= 32'd0;
            mem_err_q      <= 1'b0;
            mem_err_addr_q <= 32'd0;
        end else begin
            reg_write_q    <= reg_write_d;
            result_src_q   <= result_src_d;
            rd_q           <= rd_d;
            pc_plus4_q     <= pc_plus4_d;
            alu_result_q   <= alu_result_d;
            read_data_q    <= read_data_d;
            mem_err_q      <= mem_err_d;
            mem_err_addr_q <= mem_err_addr_d;
        end
    end

    assign RegWriteW   = reg_write_q;
    assign ResultSrcW  = result_src_q;
    assign RD_W        = rd_q;
    assign PCPlus4W    = pc_plus4_q;
    assign ALU_ResultW = alu_result_q;
    assign ReadDataW   = read_data_q;
    assign MemErr      = mem_err_q;
    assign MemErrAddr  = mem_err_addr_q;

endmodule
`default_nettype wire
